// File: rtl/rx_pkg.sv
// Shared definitions for the RX deserializer and the frame buffer RAM it feeds.
package rx_pkg;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

    // Defaults shared with the RAM instantiation so both sides agree on geometry.
    localparam int RX_DATA_WIDTH = 8;
    localparam int RX_ADDR_WIDTH = 2;

endpackage

// File: rtl/rx_deser_writer_if.sv
// Serial input, consumer read address and RAM write port of the RX deserializer.
interface rx_deser_writer_if #(
    parameter int DATA_WIDTH = rx_pkg::RX_DATA_WIDTH,
    parameter int ADDR_WIDTH = rx_pkg::RX_ADDR_WIDTH
);

    logic                  rx_bit;
    logic                  rx_valid;
    logic                  rx_start;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic                  busy;
    logic                  frame_done;
    logic                  frame_err;

    // Deserializer side: consumes the bit stream, drives the RAM port.
    modport slave (
        input  rx_bit, rx_valid, rx_start, rd_addr,
        output ram_data, ram_addr, ram_we, busy, frame_done, frame_err
    );

    // Producer/consumer side: supplies bits and the read address, observes status.
    modport master (
        output rx_bit, rx_valid, rx_start, rd_addr,
        input  ram_data, ram_addr, ram_we, busy, frame_done, frame_err
    );

endinterface

// File: rtl/rx_shift_reg.sv
// Serial-in word assembler. next_word is the value the register takes on the
// coming edge, so a word can be written out on the edge its last bit arrives.
module rx_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] next_word
);

    logic [DATA_WIDTH-1:0] word;

    // Load starts a fresh word with bit_in as its first bit; shift appends bit_in.
    always_comb begin
        next_word = word;
        if (load) begin
            next_word = '0;
            if (MSB_FIRST) next_word[0] = bit_in;
            else           next_word[DATA_WIDTH-1] = bit_in;
        end else if (shift) begin
            if (MSB_FIRST) begin
                next_word    = word << 1;
                next_word[0] = bit_in;
            end else begin
                next_word               = word >> 1;
                next_word[DATA_WIDTH-1] = bit_in;
            end
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (rst) word <= '0;
        else     word <= next_word;
    end

endmodule

// File: rtl/rx_deser_writer.sv
// Deserializes a framed bit stream into words and writes one frame of
// 2**ADDR_WIDTH words into the RX buffer RAM, then yields the address port
// to the consumer.
module rx_deser_writer
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int ADDR_WIDTH = RX_ADDR_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    rx_deser_writer_if.slave bus
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e             state, state_next;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next, cnt_eff;
    logic [ADDR_WIDTH-1:0] word_idx, word_idx_next, idx_eff;
    logic [DATA_WIDTH-1:0] shift_word;
    logic                  start, accept, word_done;

    // Write stage: registered RAM port and status pulses.
    logic [DATA_WIDTH-1:0] data_p1, data_next;
    logic [ADDR_WIDTH-1:0] addr_p1, addr_next;
    logic                  vld_p1, vld_next;
    logic                  done_p1, done_next;
    logic                  err_p1, err_next;

    // A start bit is only meaningful when qualified by rx_valid; in RECV every
    // valid bit is accepted, in IDLE only a start bit is.
    assign start  = bus.rx_valid && bus.rx_start;
    assign accept = bus.rx_valid && (start || (state == RX_RECV));

    rx_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (start),
        .shift     (accept && !start),
        .bit_in    (bus.rx_bit),
        .next_word (shift_word)
    );

    // Next state, counters and write-stage values. A start bit (also an abort)
    // is handled as bit 0 of word 0 by zeroing the effective counters.
    always_comb begin
        cnt_eff       = start ? '0 : bit_cnt;
        idx_eff       = start ? '0 : word_idx;
        word_done     = accept && (cnt_eff == LAST_BIT);
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        word_idx_next = word_idx;
        data_next     = data_p1;
        addr_next     = addr_p1;
        vld_next      = 1'b0;
        done_next     = 1'b0;
        err_next      = start && (state == RX_RECV);
        if (accept) begin
            state_next    = RX_RECV;
            bit_cnt_next  = cnt_eff + CNT_W'(1);
            word_idx_next = idx_eff;
            if (word_done) begin
                bit_cnt_next  = '0;
                word_idx_next = idx_eff + ADDR_WIDTH'(1);
                data_next     = shift_word;
                addr_next     = idx_eff;
                vld_next      = 1'b1;
                if (&idx_eff) begin
                    done_next  = 1'b1;
                    state_next = RX_IDLE;
                end
            end
        end
    end

    // State, counters and write-stage registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_IDLE;
            bit_cnt  <= '0;
            word_idx <= '0;
            data_p1  <= '0;
            addr_p1  <= '0;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            word_idx <= word_idx_next;
            data_p1  <= data_next;
            addr_p1  <= addr_next;
            vld_p1   <= vld_next;
            done_p1  <= done_next;
            err_p1   <= err_next;
        end
    end

    assign bus.ram_data   = data_p1;
    assign bus.ram_we     = vld_p1;
    assign bus.ram_addr   = vld_p1 ? addr_p1 : bus.rd_addr;
    assign bus.busy       = (state == RX_RECV);
    assign bus.frame_done = done_p1;
    assign bus.frame_err  = err_p1;

endmodule

// File: tb/tb_rx_deser_writer.sv
// Bench for rx_deser_writer: an MSB-first and an LSB-first instance, driven by
// a frame table plus hand-written abort, reset and back-to-back sequences.
module tb_rx_deser_writer;
    import rx_pkg::*;

    localparam int DW = RX_DATA_WIDTH;
    localparam int AW = RX_ADDR_WIDTH;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
        int            cyc;
    } wr_t;

    // tx: four words, first word in the top byte, each byte listing its bits in
    // transmission order (bit 7 sent first). exp: words required in the RAM.
    typedef struct {
        int          sel;
        int          gap;
        logic [31:0] tx;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   err_msb = 0;
    int   err_lsb = 0;
    wr_t  q_msb[$];
    wr_t  q_lsb[$];

    rx_deser_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bm ();
    rx_deser_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bl ();

    rx_deser_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bm.slave)
    );

    rx_deser_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bl.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? bm.busy : bl.busy;
    endfunction

    function automatic logic [31:0] outs(input int sel);
        if (sel == 0)
            return {18'b0, bm.ram_addr, bm.ram_data, bm.ram_we, bm.busy, bm.frame_done, bm.frame_err};
        return {18'b0, bl.ram_addr, bl.ram_data, bl.ram_we, bl.busy, bl.frame_done, bl.frame_err};
    endfunction

    task automatic on_write(input int sel, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic fd, input logic bz);
        wr_t e;
        if ((sel == 0 && q_msb.size() == 0) || (sel == 1 && q_lsb.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write dut%0d: addr %0d data %0h, no write required (cycle %0d)",
                     sel, a, d, cyc);
            return;
        end
        if (sel == 0) e = q_msb.pop_front();
        else          e = q_lsb.pop_front();
        chk("wr_addr", 32'(a), 32'(e.addr));
        chk("wr_data", 32'(d), 32'(e.data));
        chk("wr_frame_done", 32'(fd), 32'(e.done));
        chk("wr_cycle", cyc, e.cyc);
        chk("busy_at_write", 32'(bz), 32'(!e.done));
    endtask

    // Scoreboard side: every write is matched against the queued expectation.
    always @(negedge clk) begin
        if (bm.ram_we === 1'b1) on_write(0, bm.ram_addr, bm.ram_data, bm.frame_done, bm.busy);
        if (bl.ram_we === 1'b1) on_write(1, bl.ram_addr, bl.ram_data, bl.frame_done, bl.busy);
        if (bm.frame_done === 1'b1) chk("done_with_we_msb", 32'(bm.ram_we), 1);
        if (bl.frame_done === 1'b1) chk("done_with_we_lsb", 32'(bl.ram_we), 1);
        if (bm.frame_err === 1'b1) err_msb++;
        if (bl.frame_err === 1'b1) err_lsb++;
    end

    task automatic step(input int sel, input logic b, input logic st, input logic v);
        @(posedge clk);
        #1;
        bm.rx_bit = 1'b0; bm.rx_start = 1'b0; bm.rx_valid = 1'b0;
        bl.rx_bit = 1'b0; bl.rx_start = 1'b0; bl.rx_valid = 1'b0;
        if (sel == 0) begin
            bm.rx_bit = b; bm.rx_start = st; bm.rx_valid = v;
        end else begin
            bl.rx_bit = b; bl.rx_start = st; bl.rx_valid = v;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called right after the last bit is driven: the write is due one cycle later.
    task automatic push_exp(input int sel, input int a, input logic [DW-1:0] d, input logic done);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        e.done = done;
        e.cyc  = cyc + 1;
        if (sel == 0) q_msb.push_back(e);
        else          q_lsb.push_back(e);
    endtask

    task automatic send_word(input int sel, input logic [DW-1:0] bits, input logic first,
                             input int gap, input int a, input logic [DW-1:0] req, input logic push);
        for (int i = DW - 1; i >= 0; i--) begin
            if (!(first && i == DW - 1) && gap > 0) begin
                int g;
                g = $urandom_range(gap, 0);
                for (int k = 0; k < g; k++) begin
                    step(sel, 1'b0, 1'b0, 1'b0);
                    @(negedge clk);
                    chk("busy_in_gap", 32'(busy_of(sel)), 1);
                end
            end
            step(sel, bits[i], first && (i == DW - 1), 1'b1);
        end
        if (push) push_exp(sel, a, req, a == 3);
    endtask

    task automatic send_frame(input int sel, input logic [31:0] tx, input logic [31:0] req, input int gap);
        for (int w = 0; w < 4; w++)
            send_word(sel, tx[31-8*w -: 8], w == 0, gap, w, req[31-8*w -: 8], 1'b1);
    endtask

    initial begin
        vec_t vt[5];
        int   e0;
        vt[0] = '{sel: 0, gap: 0, tx: 32'hA53CFF01, exp: 32'hA53CFF01};
        vt[1] = '{sel: 0, gap: 5, tx: 32'hA53CFF01, exp: 32'hA53CFF01};
        vt[2] = '{sel: 1, gap: 0, tx: 32'h805AFF0F, exp: 32'h015AFFF0};
        vt[3] = '{sel: 1, gap: 3, tx: 32'hC0013396, exp: 32'h0380CC69};
        vt[4] = '{sel: 0, gap: 2, tx: 32'h00807EC3, exp: 32'h00807EC3};

        bm.rx_bit = 1'b0; bm.rx_start = 1'b0; bm.rx_valid = 1'b0; bm.rd_addr = '0;
        bl.rx_bit = 1'b0; bl.rx_start = 1'b0; bl.rx_valid = 1'b0; bl.rd_addr = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_msb", outs(0), 0);
        chk("reset_outputs_lsb", outs(1), 0);

        // Table-driven frames, both bit orders, with and without gaps
        for (int i = 0; i < 5; i++) begin
            send_frame(vt[i].sel, vt[i].tx, vt[i].exp, vt[i].gap);
            idle(3);
            chk("frame_writes_seen", (vt[i].sel == 0) ? q_msb.size() : q_lsb.size(), 0);
        end
        chk("no_err_in_clean_frames", err_msb + err_lsb, 0);

        // Abort: one full word, three stray bits, then a new start
        e0 = err_msb;
        send_word(0, 8'h11, 1'b1, 0, 0, 8'h11, 1'b1);
        step(0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        step(0, 1'b1, 1'b0, 1'b1);
        send_frame(0, 32'h22446688, 32'h22446688, 0);
        idle(3);
        chk("abort_err_pulses", err_msb - e0, 1);
        chk("abort_writes_seen", q_msb.size(), 0);

        // Reset after one and a half words
        send_word(0, 8'h5A, 1'b1, 0, 0, 8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("outputs_after_midframe_rst", outs(0), 0);
        for (int i = 0; i < 10; i++) step(0, 1'(i % 2), 1'b0, 1'b1);
        idle(2);
        @(negedge clk);
        chk("busy_without_start", 32'(bm.busy), 0);
        chk("rst_writes_seen", q_msb.size(), 0);

        // Back-to-back frames: second start lands on the frame_done cycle
        e0 = err_msb;
        send_frame(0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        send_frame(0, 32'h0F1E2D3C, 32'h0F1E2D3C, 0);
        idle(3);
        chk("b2b_no_err", err_msb - e0, 0);
        chk("b2b_writes_seen", q_msb.size(), 0);

        // Read-out address mux while idle
        bm.rd_addr = 2'd2;
        @(negedge clk);
        chk("readout_busy", 32'(bm.busy), 0);
        chk("readout_addr2", 32'(bm.ram_addr), 2);
        step(0, 1'b0, 1'b0, 1'b0);
        bm.rd_addr = 2'd1;
        @(negedge clk);
        chk("readout_addr1", 32'(bm.ram_addr), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_deser_writer.md
Name: rx_deser_writer

Overview:
- Upstream stage of the RX frame buffer RAM. Deserializes a synchronous serial bit stream into DATA_WIDTH-bit words and writes each completed word into the RAM at consecutive addresses.
- Signals frame completion, then hands the RAM address port to the downstream consumer for read-out.
- A frame is exactly 2**ADDR_WIDTH words.

Parameters:
- DATA_WIDTH, 8, word width; must equal the RAM data width.
- ADDR_WIDTH, 2, RAM address width; frame length is 2**ADDR_WIDTH words.
- MSB_FIRST, 1, 1 = first received bit is the word MSB; 0 = first received bit is the LSB.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst  in  1  synchronous, active-high reset.
- rx_bit  in  1  serial data bit, qualified by rx_valid.
- rx_valid  in  1  rx_bit is valid this cycle.
- rx_start  in  1  first bit of a new frame; honoured only when rx_valid=1.
- rd_addr  in  ADDR_WIDTH  consumer read address, muxed to ram_addr when not writing.
- ram_data  out  DATA_WIDTH  write data to the RAM.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_we  out  1  RAM write enable.
- busy  out  1  frame reception in progress.
- frame_done  out  1  one-cycle pulse: the final word of the frame is being written.
- frame_err  out  1  one-cycle pulse: an active frame was aborted by a new rx_start.

Behaviour:
- Reset: on a clk edge with rst=1, all of the following clear to 0: state (IDLE), shift register, bit_cnt, word_idx, ram_we, ram_data, wr_addr, frame_done, frame_err.
  - Reset overrides every other input on that edge.
  - A reset mid-frame discards the partial word. No write occurs.
  - RAM contents are untouched.
- State machine: two states, IDLE and RECV. busy=1 exactly in RECV (decoded from the state register).
- IDLE:
  - rx_valid=1 with rx_start=0 is ignored.
  - rx_valid=1 with rx_start=1: capture rx_bit as bit 0 of word 0, set bit_cnt=1, word_idx=0, go to RECV.
  - rx_start=1 with rx_valid=0 is ignored in all states.
- RECV, accepting bits:
  - Each rx_valid=1 cycle with rx_start=0 shifts rx_bit in.
  - MSB_FIRST=1: shift left and insert at the LSB. MSB_FIRST=0: shift right and insert at the MSB.
  - rx_valid=0 cycles are gaps. Any number are allowed with no timeout; state is held.
- RECV, word completion: on the edge that accepts the DATA_WIDTH-th bit of a word:
  - ram_data <= assembled word, including that bit.
  - wr_addr <= word_idx; ram_we <= 1 for exactly the next cycle.
  - bit_cnt <= 0; word_idx increments.
  - Write latency is 1 cycle after the last bit is sampled.
  - If word_idx == 2**ADDR_WIDTH-1, frame_done <= 1 in the same cycle as that ram_we, and state returns to IDLE. word_idx wraps to 0.
- Abort: rx_start=1 with rx_valid=1 while in RECV:
  - frame_err pulses 1 cycle. The partial word is discarded and never written.
  - Words already written remain in the RAM.
  - That bit becomes bit 0 of word 0 of a new frame; state stays RECV.
- Back-to-back frames: rx_start with rx_valid on the cycle ram_we/frame_done is high is legal. It starts a new frame and is not an abort, because state is already IDLE.
- Address mux: ram_addr = wr_addr when ram_we=1, else rd_addr (combinational).
  - The consumer must read only while busy=0. The RAM read latency of 1 cycle is the consumer's concern.
- Width rules:
  - bit_cnt is $clog2(DATA_WIDTH) bits wide, or 1 bit if DATA_WIDTH=1; it compares against DATA_WIDTH-1.
  - word_idx is ADDR_WIDTH bits wide and wraps naturally.

Decomposition:
- Shared package rx_pkg: state enum rx_state_e {RX_IDLE, RX_RECV}; localparam defaults for DATA_WIDTH and ADDR_WIDTH, shared with the RAM instantiation.
- Sub-module rx_shift_reg (parameterised DATA_WIDTH, MSB_FIRST, with load/shift enable) is natural. The FSM, counters and address mux stay in the top level.

Test Plan:
- Nominal frame, MSB_FIRST=1: send 0xA5, 0x3C, 0xFF, 0x01 with rx_start on the first bit and no gaps -> ram_we pulses at addr 0..3 with those data, each 1 cycle after the 8th bit; frame_done coincides with the addr-3 write; busy falls in the same cycle.
- Gapped input: the same frame with random 0-5 cycle rx_valid=0 gaps -> identical writes; no extra ram_we; busy holds through gaps.
- Abort: send 0x11, then 3 bits of the next word, then rx_start+valid -> one write (addr0=0x11); frame_err pulses once; the following 4 words write to addr 0..3.
- Reset mid-frame: rst asserted after 1.5 words -> at most one write (addr0); all outputs 0 the cycle after rst; bits without rx_start are then ignored.
- LSB_FIRST (MSB_FIRST=0): bits 1,0,0,0,0,0,0,0 -> word 0x01; bits 0,1,0,1,1,0,1,0 -> word 0x5A.
- Read-out and back-to-back: after frame_done, set rd_addr=2 with busy=0 -> ram_addr=2. A new rx_start on the frame_done cycle -> no frame_err, and a new frame is received.
